// File: rtl/common_types_pkg.sv
// common_types_pkg: shared widths, types, multiplier FSM states and a sign-magnitude helper.
package common_types_pkg;
  localparam int MULT_WIDTH = 32;
  typedef logic [MULT_WIDTH-1:0] word_t;
  typedef logic [2*MULT_WIDTH-1:0] dword_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  function automatic word_t magnitude(word_t v, logic s);
    return (s && v[MULT_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_step.sv
// mult_step: one shift-add slice, acc + mcand * chunk for a BPC-bit multiplier chunk.
module mult_step
  import common_types_pkg::*;
#(
  parameter int BPC = 2
) (
  input  dword_t         acc,
  input  dword_t         mcand,
  input  logic [BPC-1:0] chunk,
  output dword_t         sum
);
  dword_t pp;
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) pp = pp + (chunk[i] ? mcand << i : dword_t'(0));
    sum = acc + pp;
  end
endmodule

// File: rtl/mult_unit.sv
// mult_unit: iterative 32x32 shift-add multiplier (MUL/MULH/MULHSU/MULHU) that stalls execute until done.
module mult_unit
  import common_types_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2,
  parameter bit EARLY_OUT      = 1
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  start,
  input  logic  flush,
  input  word_t a,
  input  word_t b,
  input  logic  mult_half,
  input  logic  signed_a,
  input  logic  signed_b,
  output logic  stall,
  output logic  done,
  output word_t result
);
  localparam int ITER = MULT_WIDTH / BITS_PER_CYCLE;
  localparam int CW   = ITER > 1 ? $clog2(ITER) : 1;
  mult_state_t state, next_state;
  logic [CW-1:0] count;
  dword_t mcand, prod, step_sum, final_prod;
  word_t mplier;
  logic neg, half, zero_op, last;
  assign zero_op    = EARLY_OUT && (a == '0 || b == '0);
  assign last       = count == CW'(ITER - 1);
  assign final_prod = neg ? -step_sum : step_sum;
  mult_step #(.BPC(BITS_PER_CYCLE)) u_step (
    .acc  (prod),
    .mcand(mcand),
    .chunk(mplier[BITS_PER_CYCLE-1:0]),
    .sum  (step_sum)
  );
  always_comb begin
    next_state = IDLE;
    stall      = 1'b0;
    done       = 1'b0;
    if (!flush) begin
      case (state)
        IDLE: begin
          stall      = start;
          next_state = start ? (zero_op ? DONE : CALC) : IDLE;
        end
        CALC: begin
          stall      = 1'b1;
          next_state = last ? DONE : CALC;
        end
        default: done = 1'b1;
      endcase
    end
  end
  // Sign is stripped on entry and reapplied to the 64-bit product on the final step.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      half   <= 1'b0;
      result <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start && !flush) begin
        mcand  <= dword_t'(magnitude(a, signed_a));
        mplier <= magnitude(b, signed_b);
        neg    <= (signed_a & a[MULT_WIDTH-1]) ^ (signed_b & b[MULT_WIDTH-1]);
        half   <= mult_half;
        prod   <= '0;
        count  <= '0;
        if (zero_op) result <= '0;
      end else if (state == CALC && !flush) begin
        prod   <= step_sum;
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        count  <= count + 1'b1;
        if (last) result <= half ? final_prod[2*MULT_WIDTH-1:MULT_WIDTH] : final_prod[MULT_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: randomized and directed checks of mult_unit against a full-width arithmetic model.
module tb_mult_unit;
  logic CLK = 1'b0, nRST = 1'b0, start = 1'b0, flush = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic mult_half = 1'b0, signed_a = 1'b0, signed_b = 1'b0;
  logic stall, done;
  logic [31:0] result;
  int checks = 0, errors = 0;

  mult_unit dut (
    .CLK(CLK), .nRST(nRST), .start(start), .flush(flush), .a(a), .b(b),
    .mult_half(mult_half), .signed_a(signed_a), .signed_b(signed_b),
    .stall(stall), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(logic [31:0] x, logic [31:0] y, logic h, logic sx, logic sy);
    logic [63:0] ex, ey, p;
    ex = sx ? {{32{x[31]}}, x} : {32'h0, x};
    ey = sy ? {{32{y[31]}}, y} : {32'h0, y};
    p  = ex * ey;
    return h ? p[63:32] : p[31:0];
  endfunction

  // Presents an op at the next negedge and holds start until done; returns stall count, done cycle, result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic h, input logic sx,
                        input logic sy, output int st, output int dc, output logic [31:0] r);
    @(negedge CLK);
    a = x; b = y; mult_half = h; signed_a = sx; signed_b = sy; start = 1'b1;
    st = 0; dc = 0; r = '0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (done) begin
        dc = c;
        r  = result;
        break;
      end
      if (stall) st++;
      @(negedge CLK);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic h,
                          input logic sx, input logic sy, input logic [31:0] exp_r);
    int st, dc, exp_st;
    logic [31:0] r;
    exp_st = (x == 0 || y == 0) ? 1 : 17;
    run_op(x, y, h, sx, sy, st, dc, r);
    checks++;
    if (r !== exp_r || dc !== exp_st + 1 || st !== exp_st) begin
      errors++;
      $display("FAIL %s: a=%h b=%h result=%h exp=%h done_cycle=%0d exp=%0d stalls=%0d exp=%0d",
               name, x, y, r, exp_r, dc, exp_st + 1, st, exp_st);
    end
  endtask

  task automatic go_idle();
    @(negedge CLK);
    start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: done=%b stall=%b exp 0 0", done, stall);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: stall=%b done=%b result=%h exp 0 0 0", stall, done, result);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_directed();
    check_op("mul_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0000002A);
    go_idle();
    check_op("mulh_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000);
    go_idle();
    check_op("mulhu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE);
    go_idle();
    check_op("mulhsu_m1x2", 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    go_idle();
    check_op("mul_min_xm1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h80000000);
    go_idle();
    check_op("mulh_min_xmin", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000);
    go_idle();
  endtask

  task automatic test_back_to_back();
    check_op("early_out_a0", 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0);
    check_op("b2b_3x5", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0000000F);
    check_op("b2b_early_b0", 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    go_idle();
  endtask

  task automatic test_flush();
    int seen;
    @(negedge CLK);
    a = 32'd100; b = 32'd200; mult_half = 1'b0; signed_a = 1'b0; signed_b = 1'b0; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL flush_pre cycle %0d: stall=%b done=%b exp 1 0", c, stall, done);
      end
      if (c < 6) @(negedge CLK);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: stall=%b done=%b exp 0 0", stall, done);
    end
    @(negedge CLK);
    flush = 1'b0; start = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (done || stall) seen++;
      @(negedge CLK);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_done: busy_cycles=%0d exp 0", seen);
    end
    start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL start_with_flush: stall=%b exp 0", stall);
    end
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_flush_ignored: stall=%b done=%b exp 0 0", stall, done);
    end
    check_op("after_flush_2x3", 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd6);
    go_idle();
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    a = 32'd123; b = 32'd456; start = 1'b1; mult_half = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
    repeat (4) @(negedge CLK);
    start = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b1 || result !== 32'd6) begin
      errors++;
      $display("FAIL pre_reset_calc: stall=%b result=%h exp 1 00000006", stall, result);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: stall=%b done=%b result=%h exp 0 0 0", stall, done, result);
    end
    @(negedge CLK);
    nRST = 1'b1;
    check_op("after_reset_9x9", 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'h51);
    go_idle();
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic h, sx, sy;
    int mode;
    for (int n = 0; n < 40; n++) begin
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 7) == 0) x = '0;
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 5) == 0) x = 32'h80000000;
      mode = $urandom_range(0, 3);
      h  = mode != 0;
      sx = mode == 0 ? 1'($urandom_range(0, 1)) : mode != 3;
      sy = mode == 0 ? sx : mode == 1;
      check_op("random", x, y, h, sx, sy, model(x, y, h, sx, sy));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
Iterative 32x32 multiplier for the execute stage. It consumes the multiplier controls latched by the decode-to-execute pipeline register (mult, mult_half, mult_signed_a, mult_signed_b) and the forwarded operands. It implements MUL, MULH, MULHSU and MULHU. It stalls the pipeline until its result is ready, and a flush aborts it.

Parameters:
BITS_PER_CYCLE, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8; ITER = 32/BITS_PER_CYCLE
EARLY_OUT, 1, when 1 a zero operand completes without iterating

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  execute holds a valid mult instruction (latched mult AND stage valid)
flush  input  1  execute-stage flush; abort any operation in progress
a  input  32  rs1 value after forwarding
b  input  32  rs2 value after forwarding
mult_half  input  1  0 = low 32 bits of product, 1 = high 32 bits
signed_a  input  1  treat a as two's complement
signed_b  input  1  treat b as two's complement
stall  output  1  hold the pipeline (decode-to-execute en low)
done  output  1  result valid this cycle
result  output  32  selected product half

Behaviour:
- Reset: asynchronous on nRST low. state = IDLE, counter = 0, accumulators = 0, stall = 0, done = 0, result = 0. A reset mid-operation discards all work.
- States:
  - IDLE: on start & ~flush, latch operand magnitudes into the registers (|a| if signed_a & a[31], else a; same for b). Latch neg = (signed_a & a[31]) XOR (signed_b & b[31]). Latch mult_half. Clear the 64-bit product and the counter.
  - Transition from IDLE: go to CALC. If EARLY_OUT and (a==0 or b==0), go to DONE with product = 0.
  - CALC: each cycle, add multiplicand times the low BITS_PER_CYCLE bits of the multiplier into the product (shift-add). Shift the multiplier right by BITS_PER_CYCLE and increment the counter. When counter == ITER-1, go to DONE.
  - DONE: done = 1 for exactly one cycle. The final product is negated with a 64-bit two's complement when neg = 1. result = mult_half ? p[63:32] : p[31:0]. The next state is always IDLE, even if start is still high, because that start belongs to the instruction now leaving execute.
- stall (combinational) = (state==IDLE & start & ~flush) | state==CALC. stall is 0 in DONE, so the pipeline advances on the edge that ends DONE.
- Latency with defaults: stall is high for 1 + ITER = 17 cycles; done is asserted in cycle 18 after start is first seen. With an early-out zero operand, stall is high for 1 cycle and done is asserted in the next cycle.
- result holds its last value outside DONE. Only cycles with done = 1 carry meaning.
- flush has priority over all other inputs. In any state, flush sends the next state to IDLE, done is never asserted for the aborted operation, and stall drops combinationally in the same cycle.
- Width rules:
  - Magnitudes are 32-bit unsigned. The magnitude of 0x80000000 is 0x80000000, which is correct when interpreted unsigned.
  - Product accumulator is 64-bit unsigned, and the sign is applied only at the end.
  - MULHSU: signed_a = 1, signed_b = 0, so only a can contribute to neg.
- Back-to-back mult instructions: the sequence is DONE, then IDLE, then a new start is accepted. This costs one IDLE cycle in which stall = start.
- start asserted while flush is high in IDLE: ignored.

Decomposition:
- common_types_pkg holds:
  - mult_state_t enum {IDLE, CALC, DONE}
  - MULT_WIDTH = 32 constant
  - the word_t type already in use
- Sub-module: mult_step, a combinational partial-product-and-add slice for one BITS_PER_CYCLE chunk. It is instantiated once and keeps the iteration datapath separate from the FSM.
- Top level: FSM, counter, sign handling and result select.

Test Plan:
- MUL 7 x 6 (mult_half = 0, unsigned) -> stall high 17 cycles, then done = 1 with result = 0x0000002A.
- MULH 0xFFFFFFFF x 0xFFFFFFFF (both signed) -> done, result = 0x00000000 (the product is +1). MULHU on the same operands -> result = 0xFFFFFFFE.
- MULHSU a = 0xFFFFFFFF (signed), b = 0x00000002 (unsigned) -> result = 0xFFFFFFFF. MUL 0x80000000 x 0xFFFFFFFF (signed) -> result = 0x80000000.
- Early-out: a = 0, b = 0x12345678 -> stall high 1 cycle, done next cycle, result = 0. Then a back-to-back start with 3 x 5 -> result = 0x0000000F after one IDLE gap.
- Flush at CALC cycle 5 -> stall drops the same cycle, no done pulse, and state is IDLE next cycle. A following start with 2 x 3 produces 6 normally.
- nRST pulsed low mid-CALC (asynchronously, between edges) -> stall, done and result are 0 immediately. After release, a new MUL 9 x 9 gives 0x51.
